// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for mem_port_arbiter: default widths, requester ids,
// read-tracker state encodings and a saturating counter helper.
package mem_port_arbiter_pkg;

   localparam int ADDR_W_DEF   = 16;
   localparam int DATA_W_DEF   = 16;
   localparam int MAX_WAIT_DEF = 4;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_PER = 1'b1;

   typedef enum logic [1:0] {
      RD_IDLE   = 2'd0,
      RD_PEND_0 = 2'd1,
      RD_PEND_1 = 2'd2
   } rd_state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Saturating count of cycles the peripheral has been refused, plus a flag
// raised once that count reaches MAX_WAIT.
module mem_port_arbiter_wait_timer
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req,
   input  logic       gnt,
   output logic [7:0] cnt,
   output logic       starve
);

   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   logic [7:0] cnt_r;
   logic [7:0] cnt_s;

   // Next count: grow while refused, clear on grant or withdrawn request.
   always_comb begin
      cnt_s = cnt_r;
      if (req && !gnt) begin
         cnt_s = sat_inc8(cnt_r);
      end else begin
         cnt_s = 8'd0;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r <= 8'd0;
      end else begin
         cnt_r <= cnt_s;
      end
   end

   assign cnt    = cnt_r;
   assign starve = (cnt_r >= MAX_WAIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares RAM port A between the CPU (req0) and a peripheral master (req1).
// Define MEMARB_RR_EN to resolve conflicts by strict alternation instead of CPU priority.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [7:0]        starve_cnt
);

   logic              gnt0_s;
   logic              gnt1_s;
   logic              starve_s;
   logic [7:0]        wait_cnt_s;
   logic              last_win_r;
   rd_state_t         rd_state_r;
   rd_state_t         rd_state_s;
   logic              rvalid0_s;
   logic              rvalid1_s;
   logic [DATA_W-1:0] rdata0_s;
   logic [DATA_W-1:0] rdata1_s;
   logic              ram_we_s;
   logic [ADDR_W-1:0] ram_addr_s;
   logic [DATA_W-1:0] ram_wdata_s;

   mem_port_arbiter_wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_timer (
      .clk    (clk),
      .reset  (reset),
      .req    (req1),
      .gnt    (gnt1_s),
      .cnt    (wait_cnt_s),
      .starve (starve_s)
   );

   // Grant selection; exactly one grant whenever anyone requests.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (!reset) begin
         gnt0_s = 1'b0;
      end else if (req0 && req1) begin
`ifdef MEMARB_RR_EN
         if (last_win_r == REQ_CPU) begin
            gnt1_s = 1'b1;
         end else begin
            gnt0_s = 1'b1;
         end
`else
         if (starve_s) begin
            gnt1_s = 1'b1;
         end else begin
            gnt0_s = 1'b1;
         end
`endif
      end else if (req0) begin
         gnt0_s = 1'b1;
      end else if (req1) begin
         gnt1_s = 1'b1;
      end else begin
         gnt0_s = 1'b0;
      end
   end

   // RAM port mux driven by the granted requester, zero when idle.
   always_comb begin
      ram_we_s    = 1'b0;
      ram_addr_s  = {ADDR_W{1'b0}};
      ram_wdata_s = {DATA_W{1'b0}};
      if (gnt0_s) begin
         ram_we_s    = we0;
         ram_addr_s  = addr0;
         ram_wdata_s = wdata0;
      end else if (gnt1_s) begin
         ram_we_s    = we1;
         ram_addr_s  = addr1;
         ram_wdata_s = wdata1;
      end else begin
         ram_we_s    = 1'b0;
      end
   end

   // Read tracker next state and read-data steering to the owner.
   always_comb begin
      rd_state_s = RD_IDLE;
      rvalid0_s  = 1'b0;
      rvalid1_s  = 1'b0;
      rdata0_s   = {DATA_W{1'b0}};
      rdata1_s   = {DATA_W{1'b0}};
      if (gnt0_s && !we0) begin
         rd_state_s = RD_PEND_0;
      end else if (gnt1_s && !we1) begin
         rd_state_s = RD_PEND_1;
      end else begin
         rd_state_s = RD_IDLE;
      end
      case (rd_state_r)
         RD_PEND_0: begin
            rvalid0_s = 1'b1;
            rdata0_s  = ram_rdata;
         end
         RD_PEND_1: begin
            rvalid1_s = 1'b1;
            rdata1_s  = ram_rdata;
         end
         default: begin
            rvalid0_s = 1'b0;
            rvalid1_s = 1'b0;
         end
      endcase
   end

   // Read tracker state register; a reset drops any pending read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_state_r <= RD_IDLE;
      end else begin
         rd_state_r <= rd_state_s;
      end
   end

   // Remember the most recent winner for the alternation policy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_win_r <= REQ_CPU;
      end else if (gnt0_s) begin
         last_win_r <= REQ_CPU;
      end else if (gnt1_s) begin
         last_win_r <= REQ_PER;
      end else begin
         last_win_r <= last_win_r;
      end
   end

   assign gnt0       = gnt0_s;
   assign gnt1       = gnt1_s;
   assign ram_en     = gnt0_s | gnt1_s;
   assign ram_we     = ram_we_s;
   assign ram_addr   = ram_addr_s;
   assign ram_wdata  = ram_wdata_s;
   assign rvalid0    = rvalid0_s;
   assign rvalid1    = rvalid1_s;
   assign rdata0     = rdata0_s;
   assign rdata1     = rdata1_s;
   assign starve_cnt = wait_cnt_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural
// 1-cycle-latency RAM on the arbitrated port.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [15:0] addr0 = 16'h0, wdata0 = 16'h0, addr1 = 16'h0, wdata1 = 16'h0;
   logic        gnt0, rvalid0, gnt1, rvalid1;
   logic [15:0] rdata0, rdata1;
   logic        ram_en, ram_we;
   logic [15:0] ram_addr, ram_wdata;
   logic [15:0] ram_rdata = 16'h0;
   logic [7:0]  starve_cnt;
   logic [15:0] mem [0:255];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .starve_cnt(starve_cnt)
   );

   // Behavioural RAM: writes land at the edge, reads return one cycle later.
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
         else        ram_rdata <= mem[ram_addr[7:0]];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0;
      mem[8'h10] = 16'hBEEF;
      mem[8'h30] = 16'h1111;
      mem[8'h31] = 16'h2222;
      mem[8'h32] = 16'h3333;

      // Reset state: requests ignored while reset is low
      req0 = 1'b1; req1 = 1'b1;
      @(negedge clk);
      check_eq("rst_gnt0", gnt0, 1'b0);
      check_eq("rst_gnt1", gnt1, 1'b0);
      check_eq("rst_ram_en", ram_en, 1'b0);
      check_eq("rst_rvalid0", rvalid0, 1'b0);
      check_eq("rst_rdata0", rdata0, 16'h0);
      check_eq("rst_starve", starve_cnt, 8'd0);
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      next_cycle();

      // 1: CPU read of 0x0010
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
      @(negedge clk);
      check_eq("t1_gnt0", gnt0, 1'b1);
      check_eq("t1_gnt1", gnt1, 1'b0);
      check_eq("t1_ram_en", ram_en, 1'b1);
      check_eq("t1_ram_we", ram_we, 1'b0);
      check_eq("t1_ram_addr", ram_addr, 16'h0010);
      next_cycle();
      req0 = 1'b0;
      @(negedge clk);
      check_eq("t1_rvalid0", rvalid0, 1'b1);
      check_eq("t1_rdata0", rdata0, 16'hBEEF);
      check_eq("t1_rvalid1", rvalid1, 1'b0);
      check_eq("t1_rdata1", rdata1, 16'h0);
      check_eq("t1_idle_en", ram_en, 1'b0);
      next_cycle();
      @(negedge clk);
      check_eq("t1_rvalid0_off", rvalid0, 1'b0);

      // 2: both held, peripheral wins after MAX_WAIT=4 refusals
      next_cycle();
      req0 = 1'b1; req1 = 1'b1; addr0 = 16'h0010; addr1 = 16'h0011;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq($sformatf("t2_gnt0_%0d", i), gnt0, (i < 4) ? 1'b1 : 1'b0);
         check_eq($sformatf("t2_gnt1_%0d", i), gnt1, (i < 4) ? 1'b0 : 1'b1);
         check_eq($sformatf("t2_cnt_%0d", i), starve_cnt, 8'(i));
         next_cycle();
      end
      @(negedge clk);
      check_eq("t2_cnt_clr", starve_cnt, 8'd0);
      check_eq("t2_gnt0_after", gnt0, 1'b1);
      next_cycle();
      req0 = 1'b0; req1 = 1'b0;
      next_cycle();

      // 3: alternating reads 0 -> 1 -> 0
      req0 = 1'b1; addr0 = 16'h0030;
      @(negedge clk);
      check_eq("t3_a_gnt0", gnt0, 1'b1);
      next_cycle();
      req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0031;
      @(negedge clk);
      check_eq("t3_b_gnt1", gnt1, 1'b1);
      check_eq("t3_b_rvalid0", rvalid0, 1'b1);
      check_eq("t3_b_rdata0", rdata0, 16'h1111);
      check_eq("t3_b_rvalid1", rvalid1, 1'b0);
      next_cycle();
      req1 = 1'b0; req0 = 1'b1; addr0 = 16'h0032;
      @(negedge clk);
      check_eq("t3_c_gnt0", gnt0, 1'b1);
      check_eq("t3_c_rvalid1", rvalid1, 1'b1);
      check_eq("t3_c_rdata1", rdata1, 16'h2222);
      check_eq("t3_c_rvalid0", rvalid0, 1'b0);
      check_eq("t3_c_rdata0", rdata0, 16'h0);
      next_cycle();
      req0 = 1'b0;
      @(negedge clk);
      check_eq("t3_d_rvalid0", rvalid0, 1'b1);
      check_eq("t3_d_rdata0", rdata0, 16'h3333);
      check_eq("t3_d_rvalid1", rvalid1, 1'b0);
      next_cycle();

      // 4: peripheral write, then CPU read back
      req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0020; wdata1 = 16'h1234;
      @(negedge clk);
      check_eq("t4_gnt1", gnt1, 1'b1);
      check_eq("t4_ram_we", ram_we, 1'b1);
      check_eq("t4_ram_addr", ram_addr, 16'h0020);
      check_eq("t4_ram_wdata", ram_wdata, 16'h1234);
      next_cycle();
      req1 = 1'b0; we1 = 1'b0; req0 = 1'b1; addr0 = 16'h0020;
      @(negedge clk);
      check_eq("t4_gnt0", gnt0, 1'b1);
      check_eq("t4_no_rvalid1_w", rvalid1, 1'b0);
      next_cycle();
      req0 = 1'b0;
      @(negedge clk);
      check_eq("t4_rvalid0", rvalid0, 1'b1);
      check_eq("t4_rdata0", rdata0, 16'h1234);
      check_eq("t4_rvalid1", rvalid1, 1'b0);
      next_cycle();

      // 5: reset in the cycle after a read grant
      req0 = 1'b1; addr0 = 16'h0010;
      @(negedge clk);
      check_eq("t5_gnt0", gnt0, 1'b1);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_eq("t5_rvalid0", rvalid0, 1'b0);
      check_eq("t5_rdata0", rdata0, 16'h0);
      check_eq("t5_gnt0_rst", gnt0, 1'b0);
      check_eq("t5_ram_en_rst", ram_en, 1'b0);
      check_eq("t5_ram_we_rst", ram_we, 1'b0);
      req0 = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_eq("t5_rvalid0_after", rvalid0, 1'b0);
      next_cycle();

      // Peripheral withdraws while refused: counter clears, no access
      req0 = 1'b1; req1 = 1'b1;
      next_cycle();
      next_cycle();
      @(negedge clk);
      check_eq("drop_cnt_2", starve_cnt, 8'd2);
      next_cycle();
      req1 = 1'b0;
      next_cycle();
      @(negedge clk);
      check_eq("drop_cnt_clr", starve_cnt, 8'd0);
      check_eq("drop_gnt1", gnt1, 1'b0);
      next_cycle();
      req0 = 1'b0;
      next_cycle();

`ifdef MEMARB_RR_EN
      // 6: alternation; a lone CPU grant first makes the CPU the last winner
      req0 = 1'b1;
      next_cycle();
      req1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq($sformatf("t6_gnt1_%0d", i), gnt1, (i % 2 == 0) ? 1'b1 : 1'b0);
         check_eq($sformatf("t6_gnt0_%0d", i), gnt0, (i % 2 == 0) ? 1'b0 : 1'b1);
         next_cycle();
      end
      req0 = 1'b0; req1 = 1'b0;
      next_cycle();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
